// File: rtl/inst_load_arbiter_if.sv
// Read-side bundle between the instruction-load arbiter and the AXI read
// master / instruction memory: block-accept flag, start/done handshake and
// the transfer descriptor held for the duration of a read.
interface inst_load_arbiter_if #(
    parameter int unsigned AXI_ADDR_WIDTH = 42,
    parameter int unsigned MEM_REQ_W      = 16
);
    logic                      imem_wr_req;
    logic                      ap_done_rd;
    logic                      ap_start_rd;
    logic [AXI_ADDR_WIDTH-1:0] ctrl_addr_offset_rd;
    logic [MEM_REQ_W-1:0]      ctrl_xfer_size_in_bytes_rd;

    // Arbiter side: issues reads, observes completion and memory readiness.
    modport master (
        input  imem_wr_req,
        input  ap_done_rd,
        output ap_start_rd,
        output ctrl_addr_offset_rd,
        output ctrl_xfer_size_in_bytes_rd
    );

    // AXI read master / memory side.
    modport slave (
        output imem_wr_req,
        output ap_done_rd,
        input  ap_start_rd,
        input  ctrl_addr_offset_rd,
        input  ctrl_xfer_size_in_bytes_rd
    );
endinterface

// File: rtl/inst_load_arbiter.sv
// Instruction-load arbiter: collects toggle-encoded load requests from
// NUM_SRC sources, holds one request per source, and serialises them onto a
// single AXI read master with round-robin fairness (one read in flight).
// Optional feature macro: IMEM_LD_ZERO_SIZE_FILTER_EN -- when defined,
// zero-byte requests complete locally without touching AXI.
module inst_load_arbiter #(
    parameter int unsigned NUM_SRC        = 2,
    parameter int unsigned AXI_ADDR_WIDTH = 42,
    parameter int unsigned MEM_REQ_W      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_SRC-1:0]                src_ld_req_in,
    input  logic [NUM_SRC*AXI_ADDR_WIDTH-1:0] src_ld_addr,
    input  logic [NUM_SRC*MEM_REQ_W-1:0]      src_ld_req_size,
    output logic [NUM_SRC-1:0]                src_ld_done,
    output logic                              busy,
    output logic [NUM_SRC-1:0]                req_dropped,
    inst_load_arbiter_if.master               rd_if
);

    localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [NUM_SRC-1:0]        r_req_d;
    logic [NUM_SRC-1:0]        r_pending;
    logic [NUM_SRC-1:0]        r_dropped;
    logic [NUM_SRC-1:0]        r_done;
    logic [AXI_ADDR_WIDTH-1:0] r_hold_addr [NUM_SRC];
    logic [MEM_REQ_W-1:0]      r_hold_size [NUM_SRC];
    logic [IDX_W-1:0]          r_rr_ptr;
    logic [IDX_W-1:0]          r_grant;
    logic                      r_start;
    logic                      r_busy;
    logic [AXI_ADDR_WIDTH-1:0] r_addr;
    logic [MEM_REQ_W-1:0]      r_size;

    logic [NUM_SRC-1:0]        w_det;
    logic [NUM_SRC-1:0]        w_clr;
    logic                      w_grant_vld;
    logic [IDX_W-1:0]          w_grant_idx;
    logic                      w_load;
    logic                      w_complete;
    logic [IDX_W-1:0]          w_cmp_idx;
    int unsigned               w_idx;

    // Any level change on a toggle input is one request.
    assign w_det = src_ld_req_in ^ r_req_d;

    // Round-robin search: first pending source at or above rr_ptr, wrapping.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = r_rr_ptr;
        w_idx       = 0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_idx = 32'(r_rr_ptr) + k;
            if (w_idx >= NUM_SRC) begin
                w_idx = w_idx - NUM_SRC;
            end
            if (!w_grant_vld && r_pending[IDX_W'(w_idx)]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = IDX_W'(w_idx);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and transaction control decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_complete  = 1'b0;
        w_cmp_idx   = r_grant;
        case (r_state)
            S_IDLE: begin
                if (w_grant_vld && rd_if.imem_wr_req) begin
`ifdef IMEM_LD_ZERO_SIZE_FILTER_EN
                    if (r_hold_size[w_grant_idx] == '0) begin
                        w_complete = 1'b1;
                        w_cmp_idx  = w_grant_idx;
                    end else begin
                        w_load      = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
`else
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
`endif
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (rd_if.ap_done_rd) begin
                    w_complete  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // One-hot clear of the pending bit for the source being completed.
    always_comb begin
        w_clr = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            w_clr[i] = w_complete && (w_cmp_idx == IDX_W'(i));
        end
    end

    // Per-source request capture, pending tracking and sticky drop flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_d   <= '0;
            r_pending <= '0;
            r_dropped <= '0;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                r_hold_addr[i] <= '0;
                r_hold_size[i] <= '0;
            end
        end else begin
            r_req_d <= src_ld_req_in;
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (w_det[i]) begin
                    // A slot being freed this cycle may take the new request.
                    if (r_pending[i] && !w_clr[i]) begin
                        r_dropped[i] <= 1'b1;
                    end else begin
                        r_pending[i]   <= 1'b1;
                        r_hold_addr[i] <= src_ld_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                        r_hold_size[i] <= src_ld_req_size[i*MEM_REQ_W +: MEM_REQ_W];
                    end
                end else if (w_clr[i]) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    // AXI descriptor, start pulse, busy, completion toggles and rr pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_grant  <= '0;
            r_rr_ptr <= '0;
            r_addr   <= '0;
            r_size   <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= '0;
        end else begin
            r_start <= w_load;
            r_busy  <= (w_state_nxt != S_IDLE);
            if (w_load) begin
                r_grant <= w_grant_idx;
                r_addr  <= r_hold_addr[w_grant_idx];
                r_size  <= r_hold_size[w_grant_idx];
            end
            if (w_complete) begin
                r_done   <= r_done ^ w_clr;
                r_rr_ptr <= (w_cmp_idx == IDX_W'(NUM_SRC - 1)) ? '0 : w_cmp_idx + IDX_W'(1);
            end
        end
    end

    assign rd_if.ap_start_rd                = r_start;
    assign rd_if.ctrl_addr_offset_rd        = r_addr;
    assign rd_if.ctrl_xfer_size_in_bytes_rd = r_size;
    assign src_ld_done                      = r_done;
    assign busy                             = r_busy;
    assign req_dropped                      = r_dropped;

endmodule

// File: tb/tb_inst_load_arbiter.sv
// Self-checking bench for inst_load_arbiter: expected AXI starts are queued
// when requests are driven and popped as the DUT issues them; a responder
// returns completions and checks the done toggles.
module tb_inst_load_arbiter;

    localparam int unsigned N  = 2;
    localparam int unsigned AW = 42;
    localparam int unsigned SW = 16;

    typedef struct {
        int            src;
        logic [AW-1:0] addr;
        logic [SW-1:0] size;
    } exp_t;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    src_ld_req_in;
    logic [N*AW-1:0] src_ld_addr;
    logic [N*SW-1:0] src_ld_req_size;
    logic [N-1:0]    src_ld_done;
    logic            busy;
    logic [N-1:0]    req_dropped;

    inst_load_arbiter_if #(.AXI_ADDR_WIDTH(AW), .MEM_REQ_W(SW)) rd_if ();

    inst_load_arbiter #(.NUM_SRC(N), .AXI_ADDR_WIDTH(AW), .MEM_REQ_W(SW)) dut (
        .clk             (clk),
        .reset           (rst_n),
        .src_ld_req_in   (src_ld_req_in),
        .src_ld_addr     (src_ld_addr),
        .src_ld_req_size (src_ld_req_size),
        .src_ld_done     (src_ld_done),
        .busy            (busy),
        .req_dropped     (req_dropped),
        .rd_if           (rd_if)
    );

    int            n_cmp;
    int            n_err;
    int            cyc;
    int            n_start;
    int            last_start_cyc;
    int            cur_src;
    logic [AW-1:0] cur_addr;
    int            done_dly;
    bit            resp_busy;
    bit            prev_start;
    logic [N-1:0]  exp_done;
    exp_t          exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input int s, input logic [AW-1:0] a, input logic [SW-1:0] sz);
        exp_t e;
        e.src  = s;
        e.addr = a;
        e.size = sz;
        exp_q.push_back(e);
    endtask

    task automatic toggle_src(input int s, input logic [AW-1:0] a, input logic [SW-1:0] sz);
        src_ld_addr[s*AW +: AW]     = a;
        src_ld_req_size[s*SW +: SW] = sz;
        src_ld_req_in[s]            = ~src_ld_req_in[s];
    endtask

    task automatic wait_idle(input int max_cyc);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !busy && !resp_busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("wait_idle_timeout", 64'(0), 64'(1));
    endtask

    // Start monitor: every AXI start is matched against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rd_if.ap_start_rd) begin
                n_start++;
                last_start_cyc = cyc;
                check("start_single_cycle", 64'(prev_start), 64'(0));
                if (exp_q.size() == 0) begin
                    check("start_unexpected", 64'(1), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("start_addr", 64'(rd_if.ctrl_addr_offset_rd), 64'(e.addr));
                    check("start_size", 64'(rd_if.ctrl_xfer_size_in_bytes_rd), 64'(e.size));
                    cur_src  = e.src;
                    cur_addr = e.addr;
                end
            end
            prev_start = rd_if.ap_start_rd;
        end else begin
            prev_start = 1'b0;
        end
    end

    // AXI responder: done pulse done_dly cycles after each start.
    initial begin
        rd_if.ap_done_rd = 1'b0;
        resp_busy        = 1'b0;
        exp_done         = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                exp_done = '0;
            end else if (rd_if.ap_start_rd) begin
                resp_busy = 1'b1;
                for (int c = 0; c < done_dly; c++) begin
                    @(negedge clk);
                    if (!rst_n) break;
                end
                if (rst_n) begin
                    check("addr_held", 64'(rd_if.ctrl_addr_offset_rd), 64'(cur_addr));
                    rd_if.ap_done_rd = 1'b1;
                    @(negedge clk);
                    rd_if.ap_done_rd = 1'b0;
                    exp_done[cur_src] = ~exp_done[cur_src];
                    check("done_toggle", 64'(src_ld_done), 64'(exp_done));
                    check("busy_after_done", 64'(busy), 64'(0));
                end
                resp_busy = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           t0;
        int           ns0;
        logic [N-1:0] ed;
        n_cmp           = 0;
        n_err           = 0;
        cyc             = 0;
        n_start         = 0;
        last_start_cyc  = 0;
        cur_src         = 0;
        cur_addr        = '0;
        done_dly        = 10;
        rst_n           = 1'b0;
        src_ld_req_in   = '0;
        src_ld_addr     = '0;
        src_ld_req_size = '0;
        rd_if.imem_wr_req = 1'b1;
        #1;
        check("rst_start", 64'(rd_if.ap_start_rd), 64'(0));
        check("rst_addr", 64'(rd_if.ctrl_addr_offset_rd), 64'(0));
        check("rst_size", 64'(rd_if.ctrl_xfer_size_in_bytes_rd), 64'(0));
        check("rst_done", 64'(src_ld_done), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_dropped", 64'(req_dropped), 64'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Simultaneous pair with rr_ptr=0: src0 then src1.
        push_exp(0, 42'h2000, 16'd64);
        push_exp(1, 42'h3000, 16'd128);
        toggle_src(0, 42'h2000, 16'd64);
        toggle_src(1, 42'h3000, 16'd128);
        wait_idle(200);

        // Single src0 request: start two cycles after the toggle.
        @(negedge clk);
        t0 = cyc;
        push_exp(0, 42'h1000, 16'd256);
        toggle_src(0, 42'h1000, 16'd256);
        wait_idle(200);
        check("lat_single", 64'(last_start_cyc - t0), 64'(2));

        // rr_ptr now 1: next simultaneous pair serves src1 first.
        push_exp(1, 42'h4100, 16'd32);
        push_exp(0, 42'h4000, 16'd16);
        toggle_src(0, 42'h4000, 16'd16);
        toggle_src(1, 42'h4100, 16'd32);
        wait_idle(200);

        // Second toggle on src1 while pending is dropped.
        @(negedge clk);
        ns0 = n_start;
        rd_if.imem_wr_req = 1'b0;
        toggle_src(1, 42'h6000, 16'd8);
        @(negedge clk);
        toggle_src(1, 42'h6100, 16'd8);
        @(negedge clk);
        check("dropped_set", 64'(req_dropped), 64'(2'b10));
        push_exp(1, 42'h6000, 16'd8);
        rd_if.imem_wr_req = 1'b1;
        wait_idle(200);
        check("dropped_sticky", 64'(req_dropped), 64'(2'b10));
        check("drop_one_start", 64'(n_start - ns0), 64'(1));

        // Memory not ready: request waits, start one cycle after readiness.
        @(negedge clk);
        rd_if.imem_wr_req = 1'b0;
        ns0 = n_start;
        toggle_src(0, 42'h8000, 16'd512);
        repeat (20) @(negedge clk);
        check("stall_no_start", 64'(n_start - ns0), 64'(0));
        check("stall_busy", 64'(busy), 64'(0));
        push_exp(0, 42'h8000, 16'd512);
        rd_if.imem_wr_req = 1'b1;
        t0 = cyc;
        wait_idle(200);
        check("lat_ready", 64'(last_start_cyc - t0), 64'(1));

        // Reset during WAIT_DONE abandons the read.
        @(negedge clk);
        done_dly = 40;
        ns0 = n_start;
        push_exp(0, 42'h9000, 16'd1024);
        toggle_src(0, 42'h9000, 16'd1024);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (n_start != ns0) break;
        end
        check("rst_mid_started", 64'(n_start - ns0), 64'(1));
        repeat (5) @(negedge clk);
        check("rst_mid_busy", 64'(busy), 64'(1));
        rst_n = 1'b0;
        src_ld_req_in = '0;
        #1;
        check("rst_mid_start", 64'(rd_if.ap_start_rd), 64'(0));
        check("rst_mid_addr", 64'(rd_if.ctrl_addr_offset_rd), 64'(0));
        check("rst_mid_size", 64'(rd_if.ctrl_xfer_size_in_bytes_rd), 64'(0));
        check("rst_mid_done", 64'(src_ld_done), 64'(0));
        check("rst_mid_busy0", 64'(busy), 64'(0));
        check("rst_mid_dropped", 64'(req_dropped), 64'(0));
        ns0 = n_start;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        done_dly = 10;
        repeat (30) @(negedge clk);
        check("post_rst_done", 64'(src_ld_done), 64'(0));
        check("post_rst_busy", 64'(busy), 64'(0));
        check("post_rst_no_start", 64'(n_start - ns0), 64'(0));

        // Toggle level held high across reset release is a request.
        rst_n = 1'b0;
        src_ld_addr[1*AW +: AW]     = 42'hA000;
        src_ld_req_size[1*SW +: SW] = 16'd64;
        src_ld_req_in = 2'b10;
        @(negedge clk);
        rst_n = 1'b1;
        t0 = cyc;
        push_exp(1, 42'hA000, 16'd64);
        wait_idle(200);
        check("lat_rst_level", 64'(last_start_cyc - t0), 64'(2));

        // Zero-size request.
        @(negedge clk);
`ifdef IMEM_LD_ZERO_SIZE_FILTER_EN
        ns0 = n_start;
        ed  = exp_done;
        toggle_src(0, 42'hB000, 16'd0);
        repeat (5) @(negedge clk);
        check("zero_done", 64'(src_ld_done), 64'(ed ^ 2'b01));
        check("zero_no_start", 64'(n_start - ns0), 64'(0));
        check("zero_busy", 64'(busy), 64'(0));
`else
        ed = exp_done;
        push_exp(0, 42'hB000, 16'd0);
        toggle_src(0, 42'hB000, 16'd0);
        wait_idle(200);
        check("zero_done", 64'(src_ld_done), 64'(ed ^ 2'b01));
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
